// File: rtl/astat_cond_stk.sv
// Arithmetic status register with a hardware save stack, COND/TERM evaluation
// for the sequencer, and a saturating loop counter that drives CE.
module astat_cond_stk #(
   parameter int STK_DEPTH = 4,
   parameter int CNTR_W    = 14
) (
   input  logic              DSPCLK,
   input  logic              T_RST,
   input  logic              GO_E,
   input  logic              GO_C,
   input  logic [3:0]        COND_R,
   input  logic [3:0]        TERM_R,
   input  logic              upd_alu,
   input  logic              upd_as,
   input  logic              upd_div,
   input  logic              upd_mv,
   input  logic              upd_ss,
   input  logic [7:0]        flag_in,
   input  logic              av_sticky,
   input  logic              wr_astat,
   input  logic [7:0]        wr_data,
   input  logic              push_astat,
   input  logic              pop_astat,
   input  logic              clr_err,
   input  logic              cntr_load,
   input  logic [CNTR_W-1:0] cntr_data,
   input  logic              cntr_dec,
   output logic [7:0]        ASTAT,
   output logic              CONDok_C,
   output logic              TERMok_C,
   output logic              CE,
   output logic [CNTR_W-1:0] CNTR,
   output logic              stk_empty,
   output logic              stk_full,
   output logic              stk_ovf,
   output logic              stk_unf
);

   localparam int SP_W  = $clog2(STK_DEPTH + 1);
   localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

   localparam int B_AZ = 0;
   localparam int B_AN = 1;
   localparam int B_AV = 2;
   localparam int B_AC = 3;
   localparam int B_AS = 4;
   localparam int B_AQ = 5;
   localparam int B_MV = 6;
   localparam int B_SS = 7;

   logic [7:0]        astat_q, astat_d;
   logic [3:0]        cond_e_q, term_e_q;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [CNTR_W-1:0] cntr_q, cntr_d;
   logic [7:0]        stk_q [STK_DEPTH];

   logic              stk_we;
   logic [IDX_W-1:0]  stk_wa;
   logic [7:0]        stk_wd;
   logic [IDX_W-1:0]  top_idx;
   logic [7:0]        fld_nxt;
   logic              empty, full, ce;

   function automatic logic cond_eval(input logic [3:0] c, input logic [7:0] a,
                                      input logic ce_i);
      logic lt;
      lt = a[B_AN] ^ a[B_AV];
      case (c)
         4'h0:    cond_eval = a[B_AZ];
         4'h1:    cond_eval = !a[B_AZ];
         4'h2:    cond_eval = !(lt | a[B_AZ]);
         4'h3:    cond_eval = lt | a[B_AZ];
         4'h4:    cond_eval = lt;
         4'h5:    cond_eval = !lt;
         4'h6:    cond_eval = a[B_AV];
         4'h7:    cond_eval = !a[B_AV];
         4'h8:    cond_eval = a[B_AC];
         4'h9:    cond_eval = !a[B_AC];
         4'ha:    cond_eval = a[B_AS];
         4'hb:    cond_eval = !a[B_AS];
         4'hc:    cond_eval = a[B_MV];
         4'hd:    cond_eval = !a[B_MV];
         4'he:    cond_eval = !ce_i;
         default: cond_eval = 1'b1;
      endcase
   endfunction

   assign empty   = (sp_q == '0);
   assign full    = (sp_q == SP_W'(STK_DEPTH));
   assign top_idx = IDX_W'(sp_q - SP_W'(1));
   assign ce      = (cntr_q == CNTR_W'(1));

   // Field-level update path; only used when no pop is in progress.
   always_comb begin
      fld_nxt = astat_q;
      if (upd_alu) begin
         fld_nxt[B_AZ] = flag_in[B_AZ];
         fld_nxt[B_AN] = flag_in[B_AN];
         fld_nxt[B_AC] = flag_in[B_AC];
         fld_nxt[B_AV] = av_sticky ? (flag_in[B_AV] | astat_q[B_AV]) : flag_in[B_AV];
      end
      if (upd_as)  fld_nxt[B_AS] = flag_in[B_AS];
      if (upd_div) fld_nxt[B_AQ] = flag_in[B_AQ];
      if (upd_mv)  fld_nxt[B_MV] = flag_in[B_MV];
      if (upd_ss)  fld_nxt[B_SS] = flag_in[B_SS];
   end

   always_comb begin
      astat_d = astat_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      cntr_d  = cntr_q;
      stk_we  = 1'b0;
      stk_wa  = top_idx;
      stk_wd  = astat_q;

      // Clear first so an error raised this cycle still lands.
      if (clr_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (GO_C) begin
         if (pop_astat && push_astat) begin
            stk_we = 1'b1;
            if (empty) begin
               unf_d  = 1'b1;
               stk_wa = '0;
               sp_d   = SP_W'(1);
            end else begin
               astat_d = stk_q[top_idx];
            end
         end else if (pop_astat) begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               astat_d = stk_q[top_idx];
               sp_d    = sp_q - SP_W'(1);
            end
         end else begin
            astat_d = wr_astat ? wr_data : fld_nxt;
            if (push_astat) begin
               stk_we = 1'b1;
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  stk_wa = IDX_W'(sp_q);
                  sp_d   = sp_q + SP_W'(1);
               end
            end
         end

         if (cntr_load)
            cntr_d = cntr_data;
         else if (cntr_dec && cntr_q != '0)
            cntr_d = cntr_q - CNTR_W'(1);
      end
   end

   always_ff @(posedge DSPCLK) begin
      if (T_RST) begin
         astat_q  <= '0;
         cond_e_q <= '0;
         term_e_q <= '0;
         sp_q     <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         cntr_q   <= '0;
      end else begin
         astat_q <= astat_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         cntr_q  <= cntr_d;
         if (GO_E) begin
            cond_e_q <= COND_R;
            term_e_q <= TERM_R;
         end
      end
   end

   // Stack storage is not cleared on reset; sp alone defines validity.
   always_ff @(posedge DSPCLK) begin
      if (!T_RST && stk_we)
         stk_q[stk_wa] <= stk_wd;
   end

   assign ASTAT     = astat_q;
   assign CE        = ce;
   assign CNTR      = cntr_q;
   assign stk_empty = empty;
   assign stk_full  = full;
   assign stk_ovf   = ovf_q;
   assign stk_unf   = unf_q;
   assign CONDok_C  = cond_eval(cond_e_q, astat_q, ce);
   assign TERMok_C  = (term_e_q == 4'hf) ? 1'b0 : !cond_eval(term_e_q, astat_q, ce);

endmodule

// File: tb/tb_astat_cond_stk.sv
// Directed-vector bench for astat_cond_stk with hand-computed expectations.
module tb_astat_cond_stk;

   localparam int CW = 14;

   logic          DSPCLK = 1'b0;
   logic          T_RST, GO_E, GO_C;
   logic [3:0]    COND_R, TERM_R;
   logic          upd_alu, upd_as, upd_div, upd_mv, upd_ss;
   logic [7:0]    flag_in;
   logic          av_sticky, wr_astat;
   logic [7:0]    wr_data;
   logic          push_astat, pop_astat, clr_err, cntr_load, cntr_dec;
   logic [CW-1:0] cntr_data;
   logic [7:0]    ASTAT;
   logic          CONDok_C, TERMok_C, CE;
   logic [CW-1:0] CNTR;
   logic          stk_empty, stk_full, stk_ovf, stk_unf;

   int checks = 0;
   int failures = 0;

   astat_cond_stk #(.STK_DEPTH(4), .CNTR_W(CW)) dut (
      .DSPCLK(DSPCLK), .T_RST(T_RST), .GO_E(GO_E), .GO_C(GO_C),
      .COND_R(COND_R), .TERM_R(TERM_R),
      .upd_alu(upd_alu), .upd_as(upd_as), .upd_div(upd_div), .upd_mv(upd_mv),
      .upd_ss(upd_ss), .flag_in(flag_in), .av_sticky(av_sticky),
      .wr_astat(wr_astat), .wr_data(wr_data),
      .push_astat(push_astat), .pop_astat(pop_astat), .clr_err(clr_err),
      .cntr_load(cntr_load), .cntr_data(cntr_data), .cntr_dec(cntr_dec),
      .ASTAT(ASTAT), .CONDok_C(CONDok_C), .TERMok_C(TERMok_C), .CE(CE),
      .CNTR(CNTR), .stk_empty(stk_empty), .stk_full(stk_full),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   always #5 DSPCLK = ~DSPCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      upd_alu = 0; upd_as = 0; upd_div = 0; upd_mv = 0; upd_ss = 0;
      wr_astat = 0; push_astat = 0; pop_astat = 0; clr_err = 0;
      cntr_load = 0; cntr_dec = 0;
   endtask

   task automatic tick();
      @(posedge DSPCLK);
      #1;
      idle();
   endtask

   logic [15:0] cond_tbl;
   logic [15:0] term_tbl;
   logic [7:0]  pop_exp [4];
   logic [CW-1:0] cnt_exp [4];
   logic          ce_exp  [4];

   initial begin
      idle();
      T_RST = 1; GO_E = 0; GO_C = 0; COND_R = 0; TERM_R = 0;
      flag_in = 0; av_sticky = 0; wr_data = 0; cntr_data = 0;
      tick(); tick();
      T_RST = 0; GO_C = 1; GO_E = 1;

      chk("rst_astat", ASTAT, 8'h00);
      chk("rst_cntr", CNTR, 0);
      chk("rst_ce", CE, 0);
      chk("rst_empty", stk_empty, 1);
      chk("rst_full", stk_full, 0);
      chk("rst_ovf", stk_ovf, 0);
      chk("rst_unf", stk_unf, 0);
      chk("rst_cond", CONDok_C, 0);
      chk("rst_term", TERMok_C, 1);

      upd_alu = 1; flag_in = 8'h05; tick();
      chk("alu_astat", ASTAT, 8'h05);
      chk("alu_cond0", CONDok_C, 1);
      chk("alu_term0", TERMok_C, 0);

      av_sticky = 1; upd_alu = 1; flag_in = 8'h00; tick();
      chk("av_sticky", ASTAT, 8'h04);
      av_sticky = 0; upd_alu = 1; flag_in = 8'h00; tick();
      chk("av_nonsticky", ASTAT, 8'h00);
      upd_ss = 1; upd_mv = 1; flag_in = 8'hFF; tick();
      chk("upd_ss_mv", ASTAT, 8'hC0);
      upd_div = 1; upd_as = 1; flag_in = 8'hFF; tick();
      chk("upd_aq_as", ASTAT, 8'hF0);

      // AN=1 only, CE=0
      wr_astat = 1; wr_data = 8'h02; tick();
      chk("wr_astat", ASTAT, 8'h02);
      cond_tbl = 16'hEA9A;
      term_tbl = 16'h1565;
      for (int i = 0; i < 16; i++) begin
         COND_R = 4'(i); TERM_R = 4'(i); tick();
         chk($sformatf("cond_%0h", i), CONDok_C, cond_tbl[i]);
         chk($sformatf("term_%0h", i), TERMok_C, term_tbl[i]);
      end
      GO_E = 0; COND_R = 4'h0; TERM_R = 4'h0; tick();
      chk("go_e_hold_c", CONDok_C, 1);
      chk("go_e_hold_t", TERMok_C, 0);
      GO_E = 1;

      // Fill the stack: pushes 11,22,33,44 then overflow pushes 55 over 44
      wr_astat = 1; wr_data = 8'h11; tick();
      for (int i = 0; i < 4; i++) begin
         push_astat = 1; wr_astat = 1; wr_data = 8'h22 + 8'(i) * 8'h11; tick();
         chk($sformatf("push%0d_full", i), stk_full, (i == 3));
      end
      chk("push_astat_val", ASTAT, 8'h55);
      chk("push4_ovf", stk_ovf, 0);
      push_astat = 1; wr_astat = 1; wr_data = 8'h66; tick();
      chk("push5_ovf", stk_ovf, 1);
      chk("push5_full", stk_full, 1);
      chk("push5_astat", ASTAT, 8'h66);
      pop_exp[0] = 8'h55; pop_exp[1] = 8'h33; pop_exp[2] = 8'h22; pop_exp[3] = 8'h11;
      for (int i = 0; i < 4; i++) begin
         pop_astat = 1; tick();
         chk($sformatf("pop%0d", i), ASTAT, pop_exp[i]);
      end
      chk("pop_empty", stk_empty, 1);
      chk("pop4_unf", stk_unf, 0);
      pop_astat = 1; tick();
      chk("pop5_unf", stk_unf, 1);
      chk("pop5_astat", ASTAT, 8'h11);
      chk("pop5_ovf_kept", stk_ovf, 1);
      clr_err = 1; tick();
      chk("clr_ovf", stk_ovf, 0);
      chk("clr_unf", stk_unf, 0);
      pop_astat = 1; clr_err = 1; tick();
      chk("set_beats_clr", stk_unf, 1);
      clr_err = 1; tick();
      chk("clr_unf2", stk_unf, 0);

      // Swap: ASTAT=11 with top=22
      wr_astat = 1; wr_data = 8'h22; tick();
      push_astat = 1; tick();
      wr_astat = 1; wr_data = 8'h11; tick();
      push_astat = 1; pop_astat = 1; tick();
      chk("swap_astat", ASTAT, 8'h22);
      chk("swap_depth", stk_empty, 0);
      pop_astat = 1; tick();
      chk("swap_top", ASTAT, 8'h11);
      chk("swap_empty", stk_empty, 1);

      push_astat = 1; pop_astat = 1; tick();
      chk("pp_empty_unf", stk_unf, 1);
      chk("pp_empty_sp", stk_empty, 0);
      chk("pp_empty_astat", ASTAT, 8'h11);
      wr_astat = 1; wr_data = 8'h77; tick();
      pop_astat = 1; tick();
      chk("pp_empty_entry0", ASTAT, 8'h11);
      chk("pp_empty_after", stk_empty, 1);
      clr_err = 1; tick();

      // Counter 3,2,1,0,0 with COND/TERM code e
      COND_R = 4'he; TERM_R = 4'he;
      cntr_load = 1; cntr_data = 3; tick();
      chk("cnt_load", CNTR, 3);
      chk("cnt_load_ce", CE, 0);
      cnt_exp[0] = 2; cnt_exp[1] = 1; cnt_exp[2] = 0; cnt_exp[3] = 0;
      ce_exp[0] = 0;  ce_exp[1] = 1;  ce_exp[2] = 0;  ce_exp[3] = 0;
      for (int i = 0; i < 4; i++) begin
         cntr_dec = 1; tick();
         chk($sformatf("cnt_dec%0d", i), CNTR, cnt_exp[i]);
         chk($sformatf("ce_%0d", i), CE, ce_exp[i]);
         chk($sformatf("cond_e_%0d", i), CONDok_C, !ce_exp[i]);
         chk($sformatf("term_e_%0d", i), TERMok_C, ce_exp[i]);
      end
      cntr_load = 1; cntr_dec = 1; cntr_data = 5; tick();
      chk("load_over_dec", CNTR, 5);

      GO_C = 0; upd_alu = 1; flag_in = 8'hFF; push_astat = 1; cntr_dec = 1; tick();
      chk("goc0_astat", ASTAT, 8'h11);
      chk("goc0_stack", stk_empty, 1);
      chk("goc0_cntr", CNTR, 5);
      GO_C = 1;

      wr_astat = 1; wr_data = 8'h3C; tick();
      push_astat = 1; tick();
      wr_astat = 1; wr_data = 8'h99; pop_astat = 1; tick();
      chk("pop_over_wr", ASTAT, 8'h3C);

      push_astat = 1; tick();
      T_RST = 1; push_astat = 1; upd_alu = 1; flag_in = 8'hFF;
      cntr_load = 1; cntr_data = 7; tick();
      T_RST = 0;
      chk("midrst_astat", ASTAT, 8'h00);
      chk("midrst_cntr", CNTR, 0);
      chk("midrst_empty", stk_empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
